// File: rtl/hazard_pkg.sv
// Shared types and helpers for the decode-stage hazard scoreboard.
// Entry field widths here set the defaults used by hazard_scoreboard.
package hazard_pkg;

  localparam int SB_REG_ADDR_W = 5;
  localparam int SB_TNEW_W     = 2;

  localparam int unsigned FWD_GRF = 0;

  typedef struct packed {
    logic                     valid;
    logic [SB_REG_ADDR_W-1:0] rd;
    logic [SB_TNEW_W-1:0]     tnew;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '{valid: 1'b0, rd: '0, tnew: '0};

  function automatic logic [SB_TNEW_W-1:0] sat_dec(input logic [SB_TNEW_W-1:0] v);
    return (v == {SB_TNEW_W{1'b0}}) ? {SB_TNEW_W{1'b0}} : v - {{(SB_TNEW_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/hazard_port_check.sv
// One decode read port: finds the youngest in-flight writer of the source
// register and turns its remaining latency into a stall or a forward select.
module hazard_port_check
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = SB_REG_ADDR_W,
  parameter int TNEW_W     = SB_TNEW_W,
  parameter int STAGES     = 3,
  parameter int SEL_W      = $clog2(STAGES + 1)
) (
  input  logic                         valid_i,
  input  logic                         used_i,
  input  logic [REG_ADDR_W-1:0]        addr_i,
  input  logic [TNEW_W-1:0]            tuse_i,
  input  logic [STAGES-1:0]            ent_valid_i,
  input  logic [STAGES*REG_ADDR_W-1:0] ent_rd_i,
  input  logic [STAGES*TNEW_W-1:0]     ent_tnew_i,
  output logic                         port_stall_o,
  output logic [SEL_W-1:0]             fwd_sel_o
);

  logic              active_s;
  logic [STAGES-1:0] match_s;
  logic              hit_s;
  logic [SEL_W-1:0]  hit_idx_s;
  logic [TNEW_W-1:0] hit_tnew_s;

  assign active_s = valid_i & used_i & (addr_i != {REG_ADDR_W{1'b0}});

  // Per-stage address compare against every valid entry.
  always_comb begin
    match_s = '0;
    for (int k = 0; k < STAGES; k++) begin
      match_s[k] = ent_valid_i[k] & (ent_rd_i[k*REG_ADDR_W +: REG_ADDR_W] == addr_i);
    end
  end

  // Walk oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    hit_s      = 1'b0;
    hit_idx_s  = '0;
    hit_tnew_s = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      hit_s      = match_s[k] ? 1'b1 : hit_s;
      hit_idx_s  = match_s[k] ? SEL_W'(k + 1) : hit_idx_s;
      hit_tnew_s = match_s[k] ? ent_tnew_i[k*TNEW_W +: TNEW_W] : hit_tnew_s;
    end
  end

  // A ready result (tnew=0) is forwarded; a later one either stalls or waits downstream.
  always_comb begin
    port_stall_o = 1'b0;
    fwd_sel_o    = SEL_W'(FWD_GRF);
    if (active_s && hit_s) begin
      port_stall_o = (hit_tnew_s > tuse_i);
      if (hit_tnew_s == {TNEW_W{1'b0}}) begin
        fwd_sel_o = hit_idx_s;
      end else begin
        fwd_sel_o = SEL_W'(FWD_GRF);
      end
    end else begin
      port_stall_o = 1'b0;
      fwd_sel_o    = SEL_W'(FWD_GRF);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage stall/forward controller: shift register of in-flight GRF
// writers, per-port hazard checks, mul/div interlock and a stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = SB_REG_ADDR_W,
  parameter int TNEW_W     = SB_TNEW_W,
  parameter int STAGES     = 3,
  parameter int NUM_READ   = 2,
  parameter int SEL_W      = $clog2(STAGES + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           id_valid,
  input  logic                           id_we,
  input  logic [REG_ADDR_W-1:0]          id_rd,
  input  logic [TNEW_W-1:0]              id_tnew,
  input  logic [NUM_READ-1:0]            id_rs_used,
  input  logic [NUM_READ*REG_ADDR_W-1:0] id_rs_addr,
  input  logic [NUM_READ*TNEW_W-1:0]     id_rs_tuse,
  input  logic                           id_is_md,
  input  logic                           md_busy,
  input  logic                           flush,
  output logic                           stall,
  output logic [NUM_READ*SEL_W-1:0]      fwd_sel,
  output logic [31:0]                    stall_cnt
);

  sb_entry_t [STAGES-1:0]        ent_q;
  sb_entry_t [STAGES-1:0]        ent_d;
  logic [31:0]                   cnt_q;
  logic [31:0]                   cnt_d;

  logic [STAGES-1:0]             ent_valid_s;
  logic [STAGES*REG_ADDR_W-1:0]  ent_rd_s;
  logic [STAGES*TNEW_W-1:0]      ent_tnew_s;
  logic [NUM_READ-1:0]           port_stall_s;
  logic                          md_stall_s;
  logic                          stall_s;
  logic                          issue_s;

  for (genvar k = 0; k < STAGES; k++) begin : g_flat
    assign ent_valid_s[k]                          = ent_q[k].valid;
    assign ent_rd_s[k*REG_ADDR_W +: REG_ADDR_W]    = ent_q[k].rd;
    assign ent_tnew_s[k*TNEW_W +: TNEW_W]          = ent_q[k].tnew;
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_port
    hazard_port_check #(
      .REG_ADDR_W (REG_ADDR_W),
      .TNEW_W     (TNEW_W),
      .STAGES     (STAGES),
      .SEL_W      (SEL_W)
    ) u_check (
      .valid_i      (id_valid),
      .used_i       (id_rs_used[p]),
      .addr_i       (id_rs_addr[p*REG_ADDR_W +: REG_ADDR_W]),
      .tuse_i       (id_rs_tuse[p*TNEW_W +: TNEW_W]),
      .ent_valid_i  (ent_valid_s),
      .ent_rd_i     (ent_rd_s),
      .ent_tnew_i   (ent_tnew_s),
      .port_stall_o (port_stall_s[p]),
      .fwd_sel_o    (fwd_sel[p*SEL_W +: SEL_W])
    );
  end

  assign md_stall_s = id_valid & id_is_md & md_busy;
  assign stall_s    = ~flush & ((|port_stall_s) | md_stall_s);
  assign issue_s    = id_valid & ~stall_s & ~flush;

  // Next entry vector: decode (or a bubble) into stage 1, older stages age by one.
  always_comb begin
    ent_d = ent_q;
    if (issue_s) begin
      ent_d[0].valid = 1'b1;
      ent_d[0].rd    = id_we ? id_rd : {REG_ADDR_W{1'b0}};
      ent_d[0].tnew  = id_tnew;
    end else begin
      ent_d[0] = SB_BUBBLE;
    end
    for (int k = 1; k < STAGES; k++) begin
      ent_d[k]      = ent_q[k-1];
      ent_d[k].tnew = sat_dec(ent_q[k-1].tnew);
    end
  end

  // Saturating count of cycles in which decode was held.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_s && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Scoreboard state; reset drops every tracked writer at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_q <= {STAGES{SB_BUBBLE}};
      cnt_q <= 32'd0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall     = stall_s;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic        id_we;
  logic [4:0]  id_rd;
  logic [1:0]  id_tnew;
  logic [1:0]  id_rs_used;
  logic [9:0]  id_rs_addr;
  logic [3:0]  id_rs_tuse;
  logic        id_is_md;
  logic        md_busy;
  logic        flush;
  logic        stall;
  logic [3:0]  fwd_sel;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  hazard_scoreboard dut (
    .clk        (clk),
    .reset      (reset),
    .id_valid   (id_valid),
    .id_we      (id_we),
    .id_rd      (id_rd),
    .id_tnew    (id_tnew),
    .id_rs_used (id_rs_used),
    .id_rs_addr (id_rs_addr),
    .id_rs_tuse (id_rs_tuse),
    .id_is_md   (id_is_md),
    .md_busy    (md_busy),
    .flush      (flush),
    .stall      (stall),
    .fwd_sel    (fwd_sel),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_we = 1'b0; id_rd = 5'd0; id_tnew = 2'd0;
    id_rs_used = 2'b00; id_rs_addr = 10'd0; id_rs_tuse = 4'd0;
    id_is_md = 1'b0; md_busy = 1'b0; flush = 1'b0;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic issue(input logic [4:0] rd, input logic [1:0] tnew);
    idle();
    id_valid = 1'b1; id_we = 1'b1; id_rd = rd; id_tnew = tnew;
  endtask

  task automatic reader(input logic [1:0] used, input logic [4:0] a0, input logic [1:0] t0,
                        input logic [4:0] a1, input logic [1:0] t1);
    idle();
    id_valid = 1'b1; id_rs_used = used;
    id_rs_addr = {a1, a0}; id_rs_tuse = {t1, t0};
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #2;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_fwd", {28'd0, fwd_sel}, 32'd0);
    check("rst_cnt", stall_cnt, 32'd0);
    #10 reset = 1'b1;
    tick();

    // load-use: lw $8 tnew=2, then addu reading $8 with tuse=1
    issue(5'd8, 2'd2);
    #1 check("lu_issue_stall", {31'd0, stall}, 32'd0);
    tick();
    reader(2'b01, 5'd8, 2'd1, 5'd0, 2'd0);
    id_we = 1'b1; id_rd = 5'd10; id_tnew = 2'd1;
    #1 check("lu_stall", {31'd0, stall}, 32'd1);
    check("lu_stall_fwd", {28'd0, fwd_sel}, 32'd0);
    tick();
    check("lu_go_stall", {31'd0, stall}, 32'd0);
    check("lu_go_fwd", {28'd0, fwd_sel}, 32'd0);
    check("lu_cnt", stall_cnt, 32'd1);
    tick();
    drain();

    // ready result in stage 2 forwarded to both ports
    issue(5'd8, 2'd1);
    tick();
    idle();
    tick();
    reader(2'b11, 5'd8, 2'd0, 5'd8, 2'd0);
    #1 check("e2_stall", {31'd0, stall}, 32'd0);
    check("e2_fwd", {28'd0, fwd_sel}, 32'd10);
    drain();

    // ALU chain into beq
    issue(5'd9, 2'd0);
    tick();
    reader(2'b11, 5'd9, 2'd0, 5'd9, 2'd0);
    #1 check("alu_stall", {31'd0, stall}, 32'd0);
    check("alu_fwd", {28'd0, fwd_sel}, 32'd5);
    drain();

    // shadowing: two ready writers of $3, youngest wins
    issue(5'd3, 2'd0);
    tick();
    issue(5'd3, 2'd0);
    tick();
    reader(2'b01, 5'd3, 2'd0, 5'd0, 2'd0);
    #1 check("shadow_fwd", {28'd0, fwd_sel}, 32'd1);
    check("shadow_stall", {31'd0, stall}, 32'd0);
    id_rs_addr = 10'd0;
    #1 check("r0_fwd", {28'd0, fwd_sel}, 32'd0);
    check("r0_stall", {31'd0, stall}, 32'd0);
    id_rs_addr = 10'd3; id_rs_used = 2'b00;
    #1 check("unused_fwd", {28'd0, fwd_sel}, 32'd0);
    drain();

    // younger late writer shadows an older ready one; flush overrides the stall
    issue(5'd4, 2'd0);
    tick();
    issue(5'd4, 2'd2);
    tick();
    reader(2'b01, 5'd4, 2'd1, 5'd0, 2'd0);
    id_we = 1'b1; id_rd = 5'd12; id_tnew = 2'd2;
    #1 check("shadow_late_stall", {31'd0, stall}, 32'd1);
    check("shadow_late_fwd", {28'd0, fwd_sel}, 32'd0);
    flush = 1'b1;
    #1 check("flush_stall", {31'd0, stall}, 32'd0);
    tick();
    check("flush_cnt", stall_cnt, 32'd1);
    reader(2'b11, 5'd12, 2'd0, 5'd4, 2'd1);
    #1 check("flush_bubble_stall", {31'd0, stall}, 32'd0);
    check("flush_bubble_fwd", {28'd0, fwd_sel}, 32'd0);
    drain();

    // mul/div interlock for five busy cycles
    reader(2'b01, 5'd5, 2'd0, 5'd0, 2'd0);
    id_we = 1'b1; id_rd = 5'd5; id_tnew = 2'd1; id_is_md = 1'b1; md_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 check($sformatf("md_stall%0d", i), {31'd0, stall}, 32'd1);
      tick();
    end
    md_busy = 1'b0;
    #1 check("md_release", {31'd0, stall}, 32'd0);
    check("md_cnt", stall_cnt, 32'd6);
    tick();
    drain();

    // asynchronous reset in the middle of a stall
    issue(5'd8, 2'd2);
    tick();
    reader(2'b01, 5'd8, 2'd0, 5'd0, 2'd0);
    #1 check("ar_pre_stall", {31'd0, stall}, 32'd1);
    tick();
    check("ar_pre_cnt", stall_cnt, 32'd7);
    check("ar_pre_stall2", {31'd0, stall}, 32'd1);
    reset = 1'b0;
    #1 check("ar_cnt", stall_cnt, 32'd0);
    check("ar_stall", {31'd0, stall}, 32'd0);
    check("ar_fwd", {28'd0, fwd_sel}, 32'd0);
    reset = 1'b1;
    #1 check("ar_rel_stall", {31'd0, stall}, 32'd0);
    tick();
    check("ar_after_stall", {31'd0, stall}, 32'd0);
    check("ar_after_fwd", {28'd0, fwd_sel}, 32'd0);
    check("ar_after_cnt", stall_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
